// File: rtl/AluCtrlSig_pkg.sv
// Shared control-signal definitions for the MIPS core: opcodes, mux-select
// encodings and the multi-cycle controller state type.
package AluCtrlSig_pkg;

  localparam logic [5:0] ADD_op  = 6'b000000;
  localparam logic [5:0] J_op    = 6'b000010;
  localparam logic [5:0] BEQ_op  = 6'b000100;
  localparam logic [5:0] BNE_op  = 6'b000101;
  localparam logic [5:0] ADDI_op = 6'b001000;
  localparam logic [5:0] LW_op   = 6'b100011;
  localparam logic [5:0] SW_op   = 6'b101011;

  localparam logic [1:0] ALUSRCB_RT    = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
  localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    FETCH     = 4'd1,
    DECODE    = 4'd2,
    MEM_ADDR  = 4'd3,
    MEM_READ  = 4'd4,
    MEM_WB    = 4'd5,
    MEM_WRITE = 4'd6,
    EXEC_R    = 4'd7,
    R_WB      = 4'd8,
    EXEC_I    = 4'd9,
    I_WB      = 4'd10,
    BRANCH    = 4'd11,
    JUMP      = 4'd12,
    TRAP      = 4'd13
  } mc_state_t;

endpackage

// File: rtl/mc_control_timer.sv
// Counts consecutive wait cycles in a memory state; expire_o flags the last
// permitted wait cycle so the controller can trap on it.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam int W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == LIMIT);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS controller: sequences fetch/decode/execute/memory/writeback,
// handles memory wait with timeout, pipeline stall and sticky trap flags.
module mc_control
  import AluCtrlSig_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter bit TIMEOUT_EN  = 1'b1,
  parameter bit BNE_EN      = 1'b1,
  parameter bit J_EN        = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  input  logic       stall,
  output logic       pc_write,
  output logic       pc_write_cond_eq,
  output logic       pc_write_cond_ne,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] aluop,
  output logic [1:0] pc_src,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_o
);

  mc_state_t  state_q, state_d;
  logic [5:0] opcode_q, opcode_d;
  logic       illegalOp_q, illegalOp_d;
  logic       busErr_q, busErr_d;

  logic hold, done, waitState, timerEn, timerClear, timerExpire, timeout;

  // Stall freezes every active state; IDLE and TRAP ignore it.
  assign hold       = stall && (state_q != IDLE) && (state_q != TRAP);
  assign done       = mem_ready && !stall;
  assign waitState  = (state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE);
  assign timerEn    = waitState && !mem_ready && !stall;
  assign timeout    = TIMEOUT_EN && timerEn && timerExpire;
  assign timerClear = (state_d != state_q);

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_timer (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .clear_i (timerClear),
    .enable_i(timerEn),
    .expire_o(timerExpire)
  );

  always_comb begin
    state_d          = state_q;
    opcode_d         = opcode_q;
    illegalOp_d      = illegalOp_q;
    busErr_d         = busErr_q;
    pc_write         = 1'b0;
    pc_write_cond_eq = 1'b0;
    pc_write_cond_ne = 1'b0;
    iord             = 1'b0;
    mem_read         = 1'b0;
    mem_write        = 1'b0;
    ir_write         = 1'b0;
    mem_to_reg       = 1'b0;
    reg_dst          = 1'b0;
    reg_write        = 1'b0;
    alu_src_a        = 1'b0;
    alu_src_b        = ALUSRCB_RT;
    aluop            = ALUOP_ADD;
    pc_src           = PCSRC_ALU;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = ALUSRCB_FOUR;
        ir_write  = done;
        pc_write  = done;
        if (done) begin
          state_d = DECODE;
        end else if (timeout) begin
          state_d  = TRAP;
          busErr_d = 1'b1;
        end
      end
      DECODE: begin
        alu_src_b = ALUSRCB_IMMSH;
        opcode_d  = opcode;
        if (opcode == LW_op || opcode == SW_op) begin
          state_d = MEM_ADDR;
        end else if (opcode == ADD_op) begin
          state_d = EXEC_R;
        end else if (opcode == ADDI_op) begin
          state_d = EXEC_I;
        end else if (opcode == BEQ_op || (BNE_EN && opcode == BNE_op)) begin
          state_d = BRANCH;
        end else if (J_EN && opcode == J_op) begin
          state_d = JUMP;
        end else begin
          state_d     = TRAP;
          illegalOp_d = 1'b1;
        end
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUSRCB_IMM;
        state_d   = (opcode_q == SW_op) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (done) begin
          state_d = MEM_WB;
        end else if (timeout) begin
          state_d  = TRAP;
          busErr_d = 1'b1;
        end
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (done) begin
          state_d = FETCH;
        end else if (timeout) begin
          state_d  = TRAP;
          busErr_d = 1'b1;
        end
      end
      EXEC_R: begin
        alu_src_a = 1'b1;
        aluop     = ALUOP_FUNCT;
        state_d   = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = FETCH;
      end
      EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = ALUSRCB_IMM;
        state_d   = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        state_d   = FETCH;
      end
      BRANCH: begin
        alu_src_a        = 1'b1;
        aluop            = ALUOP_SUB;
        pc_src           = PCSRC_ALUOUT;
        pc_write_cond_eq = (opcode_q == BEQ_op);
        pc_write_cond_ne = (opcode_q != BEQ_op);
        state_d          = FETCH;
      end
      JUMP: begin
        pc_write = 1'b1;
        pc_src   = PCSRC_JUMP;
        state_d  = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = IDLE;
    endcase

    // Request levels and selects persist under stall; only strobes are killed.
    if (hold) begin
      state_d          = state_q;
      opcode_d         = opcode_q;
      illegalOp_d      = illegalOp_q;
      busErr_d         = busErr_q;
      pc_write         = 1'b0;
      pc_write_cond_eq = 1'b0;
      pc_write_cond_ne = 1'b0;
      ir_write         = 1'b0;
      reg_write        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      opcode_q    <= '0;
      illegalOp_q <= 1'b0;
      busErr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      opcode_q    <= opcode_d;
      illegalOp_q <= illegalOp_d;
      busErr_q    <= busErr_d;
    end
  end

  assign illegal_op = illegalOp_q;
  assign bus_err    = busErr_q;
  assign state_o    = state_q;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them.
module tb_mc_control;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_MEM_ADDR = 4'd3;
  localparam logic [3:0] S_MEM_READ = 4'd4, S_MEM_WB = 4'd5, S_MEM_WRITE = 4'd6, S_EXEC_R = 4'd7;
  localparam logic [3:0] S_R_WB = 4'd8, S_EXEC_I = 4'd9, S_I_WB = 4'd10, S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP = 4'd12, S_TRAP = 4'd13;

  localparam logic [5:0] OP_ADD = 6'b000000, OP_J = 6'b000010, OP_BEQ = 6'b000100;
  localparam logic [5:0] OP_BNE = 6'b000101, OP_ADDI = 6'b001000, OP_LW = 6'b100011;
  localparam logic [5:0] OP_SW = 6'b101011;

  // {pc_write, cond_eq, cond_ne, iord, mem_read, mem_write, ir_write,
  //  mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, aluop, pc_src}
  localparam logic [16:0] O_ZERO       = 17'b0;
  localparam logic [16:0] O_FETCH_GO   = {11'b10001010000, 2'b01, 2'b00, 2'b00};
  localparam logic [16:0] O_FETCH_WAIT = {11'b00001000000, 2'b01, 2'b00, 2'b00};
  localparam logic [16:0] O_DECODE     = {11'b00000000000, 2'b11, 2'b00, 2'b00};
  localparam logic [16:0] O_MEM_ADDR   = {11'b00000000001, 2'b10, 2'b00, 2'b00};
  localparam logic [16:0] O_MEM_READ   = {11'b00011000000, 6'b0};
  localparam logic [16:0] O_MEM_WRITE  = {11'b00010100000, 6'b0};
  localparam logic [16:0] O_MEM_WB     = {11'b00000001010, 6'b0};
  localparam logic [16:0] O_EXEC_R     = {11'b00000000001, 2'b00, 2'b10, 2'b00};
  localparam logic [16:0] O_R_WB       = {11'b00000000110, 6'b0};
  localparam logic [16:0] O_I_WB       = {11'b00000000010, 6'b0};
  localparam logic [16:0] O_BRANCH_EQ  = {11'b01000000001, 2'b00, 2'b01, 2'b01};
  localparam logic [16:0] O_JUMP       = {11'b10000000000, 2'b00, 2'b00, 2'b10};

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'b0;
  logic       mem_ready = 1'b0;
  logic       stall = 1'b0;
  logic       pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write;
  logic       ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a;
  logic [1:0] alu_src_b, aluop, pc_src;
  logic       illegal_op, bus_err;
  logic [3:0] state_o;
  logic [16:0] outVec;
  logic [1:0]  flagVec;

  typedef struct {
    int         stepNum;
    logic [3:0] state;
    logic [16:0] outs;
    logic [1:0] flags;
  } expT;

  expT expQ[$];
  int  assertCount = 0;
  int  failCount = 0;
  int  stepNum = 0;

  mc_control #(
    .MEM_TIMEOUT(4),
    .TIMEOUT_EN (1'b1),
    .BNE_EN     (1'b0),
    .J_EN       (1'b1)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .opcode          (opcode),
    .mem_ready       (mem_ready),
    .stall           (stall),
    .pc_write        (pc_write),
    .pc_write_cond_eq(pc_write_cond_eq),
    .pc_write_cond_ne(pc_write_cond_ne),
    .iord            (iord),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .ir_write        (ir_write),
    .mem_to_reg      (mem_to_reg),
    .reg_dst         (reg_dst),
    .reg_write       (reg_write),
    .alu_src_a       (alu_src_a),
    .alu_src_b       (alu_src_b),
    .aluop           (aluop),
    .pc_src          (pc_src),
    .illegal_op      (illegal_op),
    .bus_err         (bus_err),
    .state_o         (state_o)
  );

  assign outVec  = {pc_write, pc_write_cond_eq, pc_write_cond_ne, iord, mem_read, mem_write,
                    ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, aluop, pc_src};
  assign flagVec = {illegal_op, bus_err};

  always #5 clk = ~clk;

  task automatic compareField(input string what, input int stepN,
                              input logic [16:0] act, input logic [16:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s step %0d: got %h, expected %h", what, stepN, act, exp);
    end
  endtask

  task automatic checkOutput(input string what, input logic [3:0] es,
                             input logic [16:0] eo, input logic [1:0] ef);
    compareField({what, ".state"}, stepNum, {13'b0, state_o}, {13'b0, es});
    compareField({what, ".outs"}, stepNum, outVec, eo);
    compareField({what, ".flags"}, stepNum, {15'b0, flagVec}, {15'b0, ef});
  endtask

  // One clock of stimulus; the expectation describes the cycle just entered.
  task automatic applyStimulus(input logic [5:0] op, input logic mr, input logic st,
                               input logic [3:0] es, input logic [16:0] eo, input logic [1:0] ef);
    @(posedge clk);
    #1;
    opcode    = op;
    mem_ready = mr;
    stall     = st;
    stepNum++;
    expQ.push_back('{stepNum, es, eo, ef});
  endtask

  task automatic releaseReset();
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    mem_ready = 1'b0;
    stall     = 1'b0;
    stepNum++;
    expQ.push_back('{stepNum, S_IDLE, O_ZERO, 2'b00});
  endtask

  task automatic pulseReset(input string what);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput(what, S_IDLE, O_ZERO, 2'b00);
    repeat (2) @(posedge clk);
  endtask

  initial begin : monitor
    expT e;
    forever begin
      @(negedge clk);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        compareField("state", e.stepNum, {13'b0, state_o}, {13'b0, e.state});
        compareField("outs", e.stepNum, outVec, e.outs);
        compareField("flags", e.stepNum, {15'b0, flagVec}, {15'b0, e.flags});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    #12;
    checkOutput("reset", S_IDLE, O_ZERO, 2'b00);
    releaseReset();

    // R-type; opcode changes after DECODE must be ignored
    applyStimulus(OP_ADD, 1, 0, S_FETCH, O_FETCH_GO, 2'b00);
    applyStimulus(OP_ADD, 1, 0, S_DECODE, O_DECODE, 2'b00);
    applyStimulus(OP_LW, 1, 0, S_EXEC_R, O_EXEC_R, 2'b00);
    applyStimulus(OP_LW, 1, 0, S_R_WB, O_R_WB, 2'b00);

    // LW with two MEM_READ wait cycles: 7 cycles total
    applyStimulus(OP_LW, 1, 0, S_FETCH, O_FETCH_GO, 2'b00);
    applyStimulus(OP_LW, 1, 0, S_DECODE, O_DECODE, 2'b00);
    applyStimulus(OP_SW, 1, 0, S_MEM_ADDR, O_MEM_ADDR, 2'b00);
    applyStimulus(OP_SW, 0, 0, S_MEM_READ, O_MEM_READ, 2'b00);
    applyStimulus(OP_SW, 0, 0, S_MEM_READ, O_MEM_READ, 2'b00);
    applyStimulus(OP_SW, 1, 0, S_MEM_READ, O_MEM_READ, 2'b00);
    applyStimulus(OP_SW, 1, 0, S_MEM_WB, O_MEM_WB, 2'b00);

    // ADDI with a fetch wait and a stalled writeback
    applyStimulus(OP_ADDI, 0, 0, S_FETCH, O_FETCH_WAIT, 2'b00);
    applyStimulus(OP_ADDI, 1, 0, S_FETCH, O_FETCH_GO, 2'b00);
    applyStimulus(OP_ADDI, 1, 0, S_DECODE, O_DECODE, 2'b00);
    applyStimulus(OP_ADDI, 1, 0, S_EXEC_I, O_MEM_ADDR, 2'b00);
    applyStimulus(OP_ADDI, 1, 1, S_I_WB, O_ZERO, 2'b00);
    applyStimulus(OP_ADDI, 1, 0, S_I_WB, O_I_WB, 2'b00);

    // BEQ and J: 3 cycles each
    applyStimulus(OP_BEQ, 1, 0, S_FETCH, O_FETCH_GO, 2'b00);
    applyStimulus(OP_BEQ, 1, 0, S_DECODE, O_DECODE, 2'b00);
    applyStimulus(OP_BEQ, 1, 0, S_BRANCH, O_BRANCH_EQ, 2'b00);
    applyStimulus(OP_J, 1, 0, S_FETCH, O_FETCH_GO, 2'b00);
    applyStimulus(OP_J, 1, 0, S_DECODE, O_DECODE, 2'b00);
    applyStimulus(OP_J, 1, 0, S_JUMP, O_JUMP, 2'b00);

    // Stall during FETCH with mem_ready high: no strobes until stall drops
    for (int i = 0; i < 3; i++) begin
      applyStimulus(OP_ADD, 1, 1, S_FETCH, O_FETCH_WAIT, 2'b00);
    end
    applyStimulus(OP_ADD, 1, 0, S_FETCH, O_FETCH_GO, 2'b00);
    applyStimulus(OP_ADD, 1, 0, S_DECODE, O_DECODE, 2'b00);
    applyStimulus(OP_ADD, 1, 0, S_EXEC_R, O_EXEC_R, 2'b00);
    applyStimulus(OP_ADD, 1, 0, S_R_WB, O_R_WB, 2'b00);

    // SW: ready on the 4th non-stalled wait cycle wins over the timeout
    applyStimulus(OP_SW, 1, 0, S_FETCH, O_FETCH_GO, 2'b00);
    applyStimulus(OP_SW, 1, 0, S_DECODE, O_DECODE, 2'b00);
    applyStimulus(OP_SW, 1, 0, S_MEM_ADDR, O_MEM_ADDR, 2'b00);
    applyStimulus(OP_SW, 0, 0, S_MEM_WRITE, O_MEM_WRITE, 2'b00);
    applyStimulus(OP_SW, 0, 0, S_MEM_WRITE, O_MEM_WRITE, 2'b00);
    applyStimulus(OP_SW, 1, 1, S_MEM_WRITE, O_MEM_WRITE, 2'b00);
    applyStimulus(OP_SW, 0, 0, S_MEM_WRITE, O_MEM_WRITE, 2'b00);
    applyStimulus(OP_SW, 1, 0, S_MEM_WRITE, O_MEM_WRITE, 2'b00);

    // SW with memory never ready: 4 MEM_WRITE cycles then TRAP with bus_err
    applyStimulus(OP_SW, 1, 0, S_FETCH, O_FETCH_GO, 2'b00);
    applyStimulus(OP_SW, 1, 0, S_DECODE, O_DECODE, 2'b00);
    applyStimulus(OP_SW, 0, 0, S_MEM_ADDR, O_MEM_ADDR, 2'b00);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(OP_SW, 0, 0, S_MEM_WRITE, O_MEM_WRITE, 2'b00);
    end
    applyStimulus(OP_ADD, 1, 1, S_TRAP, O_ZERO, 2'b01);
    applyStimulus(OP_ADD, 1, 0, S_TRAP, O_ZERO, 2'b01);
    pulseReset("busErrReset");
    releaseReset();

    // BNE disabled: illegal opcode trap, cleared only by reset
    applyStimulus(OP_BNE, 1, 0, S_FETCH, O_FETCH_GO, 2'b00);
    applyStimulus(OP_BNE, 1, 0, S_DECODE, O_DECODE, 2'b00);
    applyStimulus(OP_ADD, 0, 0, S_TRAP, O_ZERO, 2'b10);
    applyStimulus(OP_ADD, 1, 1, S_TRAP, O_ZERO, 2'b10);
    pulseReset("illegalReset");
    releaseReset();

    // Asynchronous reset in the middle of a MEM_WRITE wait
    applyStimulus(OP_SW, 1, 0, S_FETCH, O_FETCH_GO, 2'b00);
    applyStimulus(OP_SW, 1, 0, S_DECODE, O_DECODE, 2'b00);
    applyStimulus(OP_SW, 0, 0, S_MEM_ADDR, O_MEM_ADDR, 2'b00);
    applyStimulus(OP_SW, 0, 0, S_MEM_WRITE, O_MEM_WRITE, 2'b00);
    @(posedge clk);
    #2;
    checkOutput("preReset", S_MEM_WRITE, O_MEM_WRITE, 2'b00);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("asyncReset", S_IDLE, O_ZERO, 2'b00);
    repeat (2) @(posedge clk);
    releaseReset();

    // Fresh SW after reset gets the full wait budget again
    applyStimulus(OP_SW, 1, 0, S_FETCH, O_FETCH_GO, 2'b00);
    applyStimulus(OP_SW, 1, 0, S_DECODE, O_DECODE, 2'b00);
    applyStimulus(OP_SW, 0, 0, S_MEM_ADDR, O_MEM_ADDR, 2'b00);
    applyStimulus(OP_SW, 0, 0, S_MEM_WRITE, O_MEM_WRITE, 2'b00);
    applyStimulus(OP_SW, 0, 0, S_MEM_WRITE, O_MEM_WRITE, 2'b00);
    applyStimulus(OP_SW, 0, 0, S_MEM_WRITE, O_MEM_WRITE, 2'b00);
    applyStimulus(OP_SW, 1, 0, S_MEM_WRITE, O_MEM_WRITE, 2'b00);
    applyStimulus(OP_ADD, 0, 0, S_FETCH, O_FETCH_WAIT, 2'b00);

    @(posedge clk);
    @(negedge clk);
    #1;
    assertCount++;
    if (expQ.size() != 0) begin
      failCount++;
      $display("[TB] FAIL drain: got %0d pending expectations, expected 0", expQ.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multi-cycle successor to the single-cycle opcode decoder: a Moore/Mealy FSM that sequences fetch, decode, execute, memory and writeback for the MIPS core over several cycles.
- Drives datapath mux selects, write strobes and aluop to the existing ALU control decoder.
- Adds features the single-cycle decoder lacked: a memory ready/valid handshake with timeout, pipeline-stall hold, per-instruction enables, and sticky trap reporting for illegal opcodes and bus errors.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive non-stalled wait cycles in one memory state before a bus error; 1..255.
- TIMEOUT_EN, 1: 0 disables the timeout, so waits are unbounded.
- BNE_EN, 1: 0 makes BNE_op decode as illegal.
- J_EN, 1: 0 makes J_op decode as illegal.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- opcode  in  6  instruction[31:26], valid from DECODE onward
- mem_ready  in  1  memory completed the current read/write this cycle
- stall  in  1  hold current state, suppress all write strobes
- pc_write  out  1  unconditional PC load
- pc_write_cond_eq  out  1  PC load if ALU zero
- pc_write_cond_ne  out  1  PC load if not ALU zero
- iord  out  1  memory address: 0=PC, 1=ALUOut
- mem_read  out  1  memory read request (level, held until mem_ready)
- mem_write  out  1  memory write request (level, held until mem_ready)
- ir_write  out  1  instruction register load
- mem_to_reg  out  1  writeback data: 0=ALUOut, 1=MDR
- reg_dst  out  1  destination: 0=rt, 1=rd
- reg_write  out  1  register file write
- alu_src_a  out  1  0=PC, 1=rs
- alu_src_b  out  2  00=rt, 01=const 4, 10=sign-ext imm, 11=imm<<2
- aluop  out  2  00 add, 01 sub, 10 funct-decoded
- pc_src  out  2  00=ALU result, 01=ALUOut, 10=jump target
- illegal_op  out  1  sticky; set on entry to TRAP via bad opcode
- bus_err  out  1  sticky; set on entry to TRAP via timeout
- state_o  out  4  current state encoding (debug)

Behaviour:
- Reset (async, rst_n=0): state=IDLE, timer=0, illegal_op=0, bus_err=0. In IDLE every output is 0 and state_o=IDLE. The first clock after release enters FETCH.
- Unlisted outputs are 0 in every state. Outputs are Moore from state; write strobes marked (R) are additionally gated by mem_ready=1 and stall=0.
- FETCH: mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, aluop=00, pc_src=00; ir_write(R)=1, pc_write(R)=1. Goes to DECODE on mem_ready.
- DECODE: alu_src_b=11, aluop=00. Next state by opcode:
  - LW_op/SW_op -> MEM_ADDR
  - ADD_op (R-type) -> EXEC_R
  - ADDI_op -> EXEC_I
  - BEQ_op/BNE_op -> BRANCH
  - J_op -> JUMP
  - other, or a disabled op -> TRAP with illegal_op=1
- MEM_ADDR: alu_src_a=1, alu_src_b=10, aluop=00. Goes to MEM_READ (LW) or MEM_WRITE (SW).
- MEM_READ: mem_read=1, iord=1. Goes to MEM_WB on mem_ready.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0. Goes to FETCH.
- MEM_WRITE: mem_write=1, iord=1. Goes to FETCH on mem_ready.
- EXEC_R: alu_src_a=1, alu_src_b=00, aluop=10. Goes to R_WB.
- R_WB: reg_write=1, reg_dst=1. Goes to FETCH.
- EXEC_I: alu_src_a=1, alu_src_b=10, aluop=00. Goes to I_WB.
- I_WB: reg_write=1, reg_dst=0. Goes to FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, aluop=01, pc_src=01; pc_write_cond_eq=1 (BEQ) or pc_write_cond_ne=1 (BNE). Goes to FETCH.
- JUMP: pc_write=1, pc_src=10. Goes to FETCH.
- TRAP: absorbing; all outputs 0 except the sticky flags. Exit only by reset.
- Latency with zero-wait memory (mem_ready=1 in first cycle):
  - J, BEQ, BNE: 3 cycles
  - R-type, ADDI, SW: 4 cycles
  - LW: 5 cycles
  - Each memory wait cycle adds 1.
- Stall: while stall=1 the state and timer hold. Request levels (mem_read/mem_write, selects) persist; pc_write, pc_write_cond_*, ir_write, reg_write are forced 0. A mem_ready arriving under stall is ignored and is not completion. Stall has no effect in IDLE or TRAP.
- Timeout:
  - Timer clears on entry to FETCH, MEM_READ or MEM_WRITE.
  - Timer increments on each cycle there with mem_ready=0 and stall=0.
  - If the timer equals MEM_TIMEOUT-1 in a waiting cycle, next state is TRAP and bus_err=1.
  - mem_ready in the same cycle wins; no trap.
- Reset mid-operation: immediate return to IDLE, flags cleared, no partial strobes.
- Opcode is sampled only in DECODE; changes in other states are ignored.

Decomposition:
- Add to AluCtrlSig_pkg:
  - mc_state_t enum (4-bit: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, R_WB, EXEC_I, I_WB, BRANCH, JUMP, TRAP)
  - ALUSRCB_* and PCSRC_* constants
  - Reuse existing *_op opcode constants.
- One sub-module: mem_wait_timer (clear/enable/expire, width $clog2(MEM_TIMEOUT+1)).

Test Plan:
- Reset release, mem_ready=1, opcode=ADD_op -> states FETCH, DECODE, EXEC_R, R_WB, FETCH. R_WB has reg_write=1, reg_dst=1; EXEC_R has aluop=10.
- LW_op with mem_ready low for 2 cycles in MEM_READ -> 7-cycle instruction. MEM_WB has reg_write=1, mem_to_reg=1; iord=1 throughout MEM_READ.
- BNE_op with BNE_EN=0 -> TRAP after DECODE, illegal_op=1, all strobes 0. Then rst_n=0 -> IDLE, illegal_op=0.
- MEM_TIMEOUT=4, SW_op, mem_ready never asserted -> 4 MEM_WRITE cycles then TRAP, bus_err=1. Repeat with mem_ready on the 4th cycle -> FETCH, no bus_err.
- stall=1 for 3 cycles during FETCH with mem_ready=1 -> state held, ir_write=0, pc_write=0. After stall drops, one cycle with ir_write=pc_write=1.
- rst_n pulsed low mid-MEM_WRITE -> outputs 0 immediately (asynchronous), state_o=IDLE, timer cleared.
